// File: rtl/sram_mem_ctrl.sv
// rtl/sram_mem_ctrl.sv - 32-bit MEM-stage accesses split into two 16-bit async SRAM accesses
module sram_mem_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'd1024,
  parameter int          ACC_CYCLES = 3,
  parameter int          SRAM_AW    = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  output logic               sram_oe_n
);

  localparam int CW = (ACC_CYCLES > 1) ? $clog2(ACC_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(ACC_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               op_wr;
  logic [SRAM_AW-2:0] word_r;
  logic [15:0]        data_hi_r;

  logic [31:0]        off;
  logic [SRAM_AW-2:0] req_word;
  logic               req;
  logic               unused_off_bits;

  // Byte offset from the SRAM window base; the low two bits select a byte within the word and are dropped.
  assign off             = address - BASE_ADDR;
  assign req_word        = off[SRAM_AW:2];
  assign unused_off_bits = ^{off[31:SRAM_AW+1], off[1:0]};
  assign req             = wr_en | rd_en;

  // The pipeline freezes on ~ready, so a request seen in IDLE must pull ready low in the same cycle.
  assign ready = ((state == IDLE) && !req) || (state == DONE);

  // Access sequencer; SRAM strobes are registered and switched on the same edge that changes phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      op_wr       <= 1'b0;
      word_r      <= '0;
      data_hi_r   <= '0;
      read_data   <= '0;
      sram_addr   <= '0;
      sram_dq_out <= '0;
      sram_dq_oe  <= 1'b0;
      sram_we_n   <= 1'b1;
      sram_oe_n   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            op_wr     <= wr_en;
            word_r    <= req_word;
            data_hi_r <= write_data[31:16];
            cnt       <= '0;
            state     <= LOW;
            sram_addr <= {req_word, 1'b0};
            if (wr_en) begin
              sram_we_n   <= 1'b0;
              sram_dq_oe  <= 1'b1;
              sram_dq_out <= write_data[15:0];
            end else begin
              sram_oe_n   <= 1'b0;
            end
          end
        end
        LOW: begin
          if (cnt == CNT_LAST) begin
            cnt         <= '0;
            state       <= HIGH;
            sram_addr   <= {word_r, 1'b1};
            sram_dq_out <= data_hi_r;
            if (!op_wr) begin
              read_data[15:0] <= sram_dq_in;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HIGH: begin
          if (cnt == CNT_LAST) begin
            cnt        <= '0;
            state      <= DONE;
            sram_we_n  <= 1'b1;
            sram_oe_n  <= 1'b1;
            sram_dq_oe <= 1'b0;
            if (!op_wr) begin
              read_data[31:16] <= sram_dq_in;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// tb/tb_sram_mem_ctrl.sv - directed self-checking bench for sram_mem_ctrl
module tb_sram_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        wr_en;
  logic        rd_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic [15:0] sram_dq_in;
  logic        sram_dq_oe;
  logic        sram_we_n;
  logic        sram_oe_n;

  int passed = 0;
  int total  = 0;

  logic [15:0] mem [0:63];

  sram_mem_ctrl #(
    .BASE_ADDR (32'd1024),
    .ACC_CYCLES(3),
    .SRAM_AW   (18)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .rd_en      (rd_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .sram_addr  (sram_addr),
    .sram_dq_out(sram_dq_out),
    .sram_dq_in (sram_dq_in),
    .sram_dq_oe (sram_dq_oe),
    .sram_we_n  (sram_we_n),
    .sram_oe_n  (sram_oe_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Asynchronous SRAM model: combinational read, write captured while we_n is low at each edge.
  assign sram_dq_in = mem[sram_addr[5:0]];
  always @(posedge clk) begin
    if (!sram_we_n) mem[sram_addr[5:0]] <= sram_dq_out;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  // Runs one access starting in an IDLE cycle (just after an edge) and checks every cycle through DONE.
  task automatic access(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] hw, input logic exp_wr, input logic [31:0] exp_rd,
                        input logic hold);
    wr_en = w; rd_en = r; address = a; write_data = d;
    #1;
    chk("accept_ready", {31'd0, ready}, 32'd0);
    for (int ph = 0; ph < 2; ph++) begin
      for (int c = 0; c < 3; c++) begin
        @(posedge clk); #1;
        if (!hold) begin
          wr_en = 1'b0; rd_en = 1'b0; address = $urandom; write_data = $urandom;
        end
        #1;
        chk($sformatf("addr_p%0d_c%0d", ph, c), {14'd0, sram_addr}, hw + ph);
        chk($sformatf("we_n_p%0d_c%0d", ph, c), {31'd0, sram_we_n}, {31'd0, !exp_wr});
        chk($sformatf("oe_n_p%0d_c%0d", ph, c), {31'd0, sram_oe_n}, {31'd0, exp_wr});
        chk($sformatf("dq_oe_p%0d_c%0d", ph, c), {31'd0, sram_dq_oe}, {31'd0, exp_wr});
        chk($sformatf("ready_p%0d_c%0d", ph, c), {31'd0, ready}, 32'd0);
        if (exp_wr) begin
          chk($sformatf("dq_out_p%0d_c%0d", ph, c), {16'd0, sram_dq_out},
              (ph == 0) ? {16'd0, d[15:0]} : {16'd0, d[31:16]});
        end
      end
    end
    @(posedge clk); #1;
    chk("done_ready", {31'd0, ready}, 32'd1);
    chk("done_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("done_oe_n", {31'd0, sram_oe_n}, 32'd1);
    chk("done_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    chk("done_read_data", read_data, exp_rd);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
    mem[2] = 16'hBEEF;
    mem[3] = 16'hDEAD;
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = 32'd0; write_data = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;

    // 1: idle after reset
    chk("rst_ready", {31'd0, ready}, 32'd1);
    chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
    chk("rst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    chk("rst_read_data", read_data, 32'd0);
    chk("rst_sram_addr", {14'd0, sram_addr}, 32'd0);

    // 2: write 0x12345678 @1032 -> halfwords 4/5
    access(1'b1, 1'b0, 32'd1032, 32'h12345678, 32'd4, 1'b1, 32'd0, 1'b0);
    @(posedge clk); #1;
    chk("t2_idle_ready", {31'd0, ready}, 32'd1);
    chk("t2_idle_addr_hold", {14'd0, sram_addr}, 32'd5);
    chk("t2_mem4", {16'd0, mem[4]}, 32'h5678);
    chk("t2_mem5", {16'd0, mem[5]}, 32'h1234);

    // 3: read back @1032
    access(1'b0, 1'b1, 32'd1032, 32'd0, 32'd4, 1'b0, 32'h12345678, 1'b0);
    @(posedge clk); #1;
    chk("t3_read_hold", read_data, 32'h12345678);

    // 4: back-to-back write @1024 then read @1028 with requests held
    access(1'b1, 1'b0, 32'd1024, 32'hA5A50F0F, 32'd0, 1'b1, 32'h12345678, 1'b1);
    @(posedge clk); #1;
    access(1'b0, 1'b1, 32'd1028, 32'd0, 32'd2, 1'b0, 32'hDEADBEEF, 1'b1);
    wr_en = 1'b0; rd_en = 1'b0;
    chk("t4_mem0", {16'd0, mem[0]}, 32'h0F0F);
    chk("t4_mem1", {16'd0, mem[1]}, 32'hA5A5);
    @(posedge clk); #1;

    // 5: both requests asserted -> write wins, read_data unchanged
    access(1'b1, 1'b1, 32'd1040, 32'hCAFEBABE, 32'd8, 1'b1, 32'hDEADBEEF, 1'b0);
    @(posedge clk); #1;
    chk("t5_mem8", {16'd0, mem[8]}, 32'hBABE);
    chk("t5_mem9", {16'd0, mem[9]}, 32'hCAFE);

    // 6: reset during HIGH phase of a write @1032 (low half already written)
    wr_en = 1'b1; address = 32'd1032; write_data = 32'h11112222;
    @(posedge clk); #1;
    wr_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("t6_in_high_addr", {14'd0, sram_addr}, 32'd5);
    chk("t6_in_high_we_n", {31'd0, sram_we_n}, 32'd0);
    rst = 1'b1;
    #1;
    chk("t6_rst_we_n", {31'd0, sram_we_n}, 32'd1);
    chk("t6_rst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
    chk("t6_rst_read_data", read_data, 32'd0);
    chk("t6_rst_ready", {31'd0, ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("t6_post_ready", {31'd0, ready}, 32'd1);
    chk("t6_mem5_untouched", {16'd0, mem[5]}, 32'h1234);
    access(1'b0, 1'b1, 32'd1032, 32'd0, 32'd4, 1'b0, 32'h12342222, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
